matrix_collector: RTL and testbench

// - Receive end of the diagonal-skew matrix stream: re-assembles a 16x16 matrix from the
//   per-cycle skewed vectors that the systolic-array feeder emits.
// - Sits at the array output (or loops back from the feeder). Captures 2N-1 wavefront beats
//   and presents a full N x N matrix with a done flag to the downstream result buffer.

---
 rtl/matrix_collector.sv | 158 +++++++++++++++
 tb/tb_matrix_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_collector.sv
// rtl/matrix_collector.sv - reassembles an N x N matrix from diagonal-skewed wavefront beats
//
// Purpose:
//   Receive end of the diagonal-skew matrix stream. Beat t carries the anti-diagonal t,
//   so lane i holds element [t-i][i] when 0 <= t-i < N. After 2N-1 accepted beats the full
//   matrix is presented on matrix_out with done held high until the next start or reset.
//
// Ports:
//   clk         in   1            single clock, posedge
//   rst_n       in   1            asynchronous active-low reset
//   start       in   1            begin (or restart) a collection; clears the matrix
//   in_valid    in   1            vector_in carries one wavefront beat
//   vector_in   in   [W] x N      lane i = column i
//   matrix_out  out  [W] x N x N  [row][col] assembled matrix
//   busy        out  1            collection in progress
//   done        out  1            matrix_out complete and stable
//   skew_err    out  1            sticky out-of-window nonzero lane flag
//
// Optional feature macro: MATRIX_COLLECTOR_SKEW_CHECK_EN
//   Defined   : skew_err flags any nonzero lane outside the valid window on an accepted beat.
//   Undefined : no check logic, skew_err tied to 0.

module matrix_collector #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] vector_in  [N],
    output logic [W-1:0] matrix_out [N][N],
    output logic         busy,
    output logic         done,
    output logic         skew_err
);

    localparam int                STEP_W    = $clog2(2*N-1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*N-2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [W-1:0]      r_matrix [N][N];
    logic              w_accept;
    logic              w_last;
    logic [N-1:0]      w_in_win;

    // Lane i is live on this step when its row index step-i lies in 0..N-1. Signed
    // arithmetic keeps lanes ahead of the wavefront (i > step) out of the window.
    always_comb begin
        w_in_win = '0;
        for (int i = 0; i < N; i++) begin
            w_in_win[i] = ((int'(r_step) - i) >= 0) && ((int'(r_step) - i) < N);
        end
    end

    // start always takes priority over a beat in the same cycle.
    assign w_accept = (r_state == ST_COLLECT) && in_valid && !start;
    assign w_last   = w_accept && (r_step == LAST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (start)       w_state_nxt = ST_COLLECT;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE:    if (start) w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step holds at the last value once the final beat lands; DONE ignores it until start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
        end else if (start) begin
            r_step <= '0;
        end else if (w_accept && !w_last) begin
            r_step <= r_step + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_matrix[r][c] <= '0;
                end
            end
        end else if (start) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_matrix[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (w_in_win[c] && ((int'(r_step) - c) == r)) begin
                        r_matrix[r][c] <= vector_in[c];
                    end
                end
            end
        end
    end

`ifdef MATRIX_COLLECTOR_SKEW_CHECK_EN
    logic r_skew_err;
    logic w_skew_hit;

    // Anything nonzero on a lane that is not yet filled or already drained means the
    // upstream skew is misaligned.
    always_comb begin
        w_skew_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_in_win[i] && (vector_in[i] != '0)) begin
                w_skew_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skew_err <= 1'b0;
        end else if (start) begin
            r_skew_err <= 1'b0;
        end else if (w_accept && w_skew_hit) begin
            r_skew_err <= 1'b1;
        end
    end

    assign skew_err = r_skew_err;
`else
    assign skew_err = 1'b0;
`endif

    assign matrix_out = r_matrix;
    assign busy       = (r_state == ST_COLLECT);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_matrix_collector.sv
// tb/tb_matrix_collector.sv - self-checking bench for matrix_collector

module tb_matrix_collector;

    localparam int N = 16;
    localparam int W = 16;

`ifdef MATRIX_COLLECTOR_SKEW_CHECK_EN
    localparam int SKEW_ON = 1;
`else
    localparam int SKEW_ON = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] vector_in  [N];
    logic [W-1:0] matrix_out [N][N];
    logic         busy;
    logic         done;
    logic         skew_err;

    // Reference: the source matrix itself. A correct collector reproduces it exactly.
    logic [W-1:0] src [N][N];

    int total = 0;
    int bad   = 0;

    matrix_collector #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .vector_in  (vector_in),
        .matrix_out (matrix_out),
        .busy       (busy),
        .done       (done),
        .skew_err   (skew_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sa;
        int la;
        int sb;
        int lb;
        bit rnd;
        int exp_done;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int count_diff();
        int n = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (matrix_out[r][c] !== src[r][c]) n++;
        return n;
    endfunction

    function automatic int count_nz();
        int n = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (matrix_out[r][c] !== '0) n++;
        return n;
    endfunction

    task automatic fill(input bit rnd);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                src[r][c] = rnd ? W'($urandom) : W'(r*32 + c + 1);
    endtask

    task automatic set_lanes(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) vector_in[i] = v;
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start    = 1'b0;
    endtask

    // Sends beats t0..t1-1 of the skewed stream of src. Idle cycles (garbage data,
    // in_valid low) follow beat sa for la cycles, beat sb for lb cycles, plus random
    // 0..2 cycles when rnd is set. done_at = edge count at which done was first seen.
    task automatic stream(input int t0, input int t1, input int sa, input int la,
                          input int sb, input int lb, input bit rnd, input int corrupt,
                          output int done_at, output int stalls);
        int edges = 0;
        int n;
        done_at = -1;
        stalls  = 0;
        for (int t = t0; t < t1; t++) begin
            for (int i = 0; i < N; i++) begin
                int d = t - i;
                vector_in[i] = (d >= 0 && d < N) ? src[d][i] : '0;
            end
            if (t == corrupt) vector_in[5] = 16'h00FF;
            in_valid = 1'b1;
            tick();
            edges++;
            if (done && done_at < 0) done_at = edges;
            in_valid = 1'b0;
            n = 0;
            if (t < 2*N-2) begin
                if (t == sa) n += la;
                if (t == sb) n += lb;
                if (rnd) n += $urandom_range(0, 2);
            end
            for (int k = 0; k < n; k++) begin
                set_lanes(W'($urandom));
                tick();
                edges++;
                if (done && done_at < 0) done_at = edges;
            end
            stalls += n;
        end
        set_lanes('0);
    endtask

    initial begin
        vec_t tbl [5];
        int   done_at;
        int   stalls;

        tbl[0] = '{sa: 5,  la: 0, sb: 20, lb: 0, rnd: 1'b0, exp_done: 31};
        tbl[1] = '{sa: 5,  la: 3, sb: 20, lb: 3, rnd: 1'b0, exp_done: 37};
        tbl[2] = '{sa: 0,  la: 1, sb: 29, lb: 2, rnd: 1'b1, exp_done: 34};
        tbl[3] = '{sa: 10, la: 4, sb: 11, lb: 1, rnd: 1'b1, exp_done: 36};
        tbl[4] = '{sa: 15, la: 2, sb: 15, lb: 2, rnd: 1'b1, exp_done: 35};

        set_lanes('0);

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_skew", int'(skew_err), 0);
        chk("rst_matrix_nz", count_nz(), 0);

        // Beat in IDLE is ignored
        set_lanes(16'h1234);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_lanes('0);
        chk("idle_beat_busy", int'(busy), 0);
        chk("idle_beat_nz", count_nz(), 0);

        // Table-driven captures with fixed stall placement
        for (int k = 0; k < 5; k++) begin
            fill(tbl[k].rnd);
            do_start();
            chk($sformatf("t%0d_busy_start", k), int'(busy), 1);
            chk($sformatf("t%0d_done_start", k), int'(done), 0);
            stream(0, 2*N-1, tbl[k].sa, tbl[k].la, tbl[k].sb, tbl[k].lb, 1'b0, -1,
                   done_at, stalls);
            chk($sformatf("t%0d_done_at", k), done_at, tbl[k].exp_done);
            chk($sformatf("t%0d_busy_end", k), int'(busy), 0);
            chk($sformatf("t%0d_matrix", k), count_diff(), 0);
            chk($sformatf("t%0d_skew", k), int'(skew_err), 0);
            if (!tbl[k].rnd) begin
                chk($sformatf("t%0d_m00", k), int'(matrix_out[0][0]), 1);
                chk($sformatf("t%0d_m1515", k), int'(matrix_out[15][15]), 496);
                chk($sformatf("t%0d_m37", k), int'(matrix_out[3][7]), 104);
            end
        end

        // Randomized captures with random stalls
        for (int k = 0; k < 4; k++) begin
            fill(1'b1);
            do_start();
            stream(0, 2*N-1, -1, 0, -1, 0, 1'b1, -1, done_at, stalls);
            chk($sformatf("r%0d_done_at", k), done_at, 2*N-1 + stalls);
            chk($sformatf("r%0d_matrix", k), count_diff(), 0);
        end

        // Restart at beat 12, with a beat in the same cycle as start
        fill(1'b0);
        do_start();
        stream(0, 12, -1, 0, -1, 0, 1'b0, -1, done_at, stalls);
        chk("restart_partial_nz", (count_nz() > 0) ? 1 : 0, 1);
        set_lanes(16'hABCD);
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        set_lanes('0);
        chk("restart_clear_nz", count_nz(), 0);
        chk("restart_busy", int'(busy), 1);
        fill(1'b1);
        stream(0, 2*N-1, -1, 0, -1, 0, 1'b0, -1, done_at, stalls);
        chk("restart_done_at", done_at, 2*N-1);
        chk("restart_matrix", count_diff(), 0);

        // Beat in DONE is ignored
        set_lanes(16'h5A5A);
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("done_beat_matrix", count_diff(), 0);
        chk("done_beat_done", int'(done), 1);

        // start together with in_valid in DONE: start wins
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        set_lanes('0);
        chk("done_start_busy", int'(busy), 1);
        chk("done_start_done", int'(done), 0);
        chk("done_start_nz", count_nz(), 0);

        // Skew error on beat 2 lane 5
        fill(1'b0);
        do_start();
        stream(0, 3, -1, 0, -1, 0, 1'b0, 2, done_at, stalls);
        chk("skew_set", int'(skew_err), SKEW_ON);
        stream(3, 2*N-1, -1, 0, -1, 0, 1'b0, -1, done_at, stalls);
        chk("skew_done", int'(done), 1);
        chk("skew_hold", int'(skew_err), SKEW_ON);
        chk("skew_matrix", count_diff(), 0);
        do_start();
        chk("skew_clear", int'(skew_err), 0);

        // Asynchronous reset at beat 17
        fill(1'b1);
        stream(0, 17, -1, 0, -1, 0, 1'b0, -1, done_at, stalls);
        in_valid = 1'b1;
        set_lanes(16'h0F0F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_skew", int'(skew_err), 0);
        chk("arst_nz", count_nz(), 0);
        tick();
        in_valid = 1'b0;
        set_lanes('0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle_busy", int'(busy), 0);
        do_start();
        stream(0, 2*N-1, -1, 0, -1, 0, 1'b0, -1, done_at, stalls);
        chk("arst_done_at", done_at, 2*N-1);
        chk("arst_matrix", count_diff(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
